// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next.sv
// Next-PC arithmetic: sequential step, or redirect by a signed instruction offset.
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_delta,
  input  logic        i_redirect,
  output logic [31:0] o_next_pc
);

  // Offset is in instructions, so scale to bytes; wrap-around is intended
  always_comb begin
    o_next_pc = i_pc;
    if (i_redirect) begin
      o_next_pc = i_pc + (i_delta << 2);
    end else begin
      o_next_pc = i_pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch FSM: issues memory reads, buffers one instruction for
// decode, and applies branch redirects from Execute.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_data,
  output logic               instr_valid,
  output logic [31:0]        instr,
  input  logic               instr_ready,
  input  logic               global_disable,
  input  logic [31:0]        delta_instruction,
  output logic [31:0]        pc,
  output logic               halted,
  output logic [STALL_W-1:0] stall_count
);

  fetch_state_t       r_state;
  logic [31:0]        r_pc;
  logic               r_imem_req;
  logic [31:0]        r_imem_addr;
  logic               r_instr_valid;
  logic [31:0]        r_instr;
  logic               r_halted;
  logic [STALL_W-1:0] r_stall_count;
  logic               r_pend_valid;
  logic [31:0]        r_pend_target;

  logic [31:0]        w_base_pc;
  logic [31:0]        w_next_pc;
  logic [31:0]        w_fetch_pc;
  logic               w_stall_sat;

  // A pending redirect becomes the base so a second redirect chains from it
  assign w_base_pc   = r_pend_valid ? r_pend_target : r_pc;
  assign w_fetch_pc  = global_disable ? w_next_pc : r_pc;
  assign w_stall_sat = (r_stall_count == {STALL_W{1'b1}});

  pc_next u_pc_next (
    .i_pc       (w_base_pc),
    .i_delta    (delta_instruction),
    .i_redirect (global_disable),
    .o_next_pc  (w_next_pc)
  );

  // Fetch state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_halted      <= 1'b1;
      r_stall_count <= {STALL_W{1'b0}};
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pc <= w_fetch_pc;
          if (run) begin
            r_state     <= ST_REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= w_fetch_pc;
            r_halted    <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            r_pend_valid <= 1'b0;
            if (global_disable) begin
              // Fetched word is on the wrong path; refetch from the target
              r_pc        <= w_next_pc;
              r_imem_addr <= w_next_pc;
            end else if (r_pend_valid) begin
              r_pc        <= r_pend_target;
              r_imem_addr <= r_pend_target;
            end else begin
              r_instr       <= imem_data;
              r_pc          <= w_next_pc;
              r_instr_valid <= 1'b1;
              r_imem_req    <= 1'b0;
              r_state       <= ST_HOLD;
            end
          end else begin
            if (!w_stall_sat) begin
              r_stall_count <= r_stall_count + {{(STALL_W-1){1'b0}}, 1'b1};
            end else begin
              r_stall_count <= r_stall_count;
            end
            if (global_disable) begin
              r_pend_valid  <= 1'b1;
              r_pend_target <= w_next_pc;
            end else begin
              r_pend_valid <= r_pend_valid;
            end
          end
        end
        ST_HOLD: begin
          if (global_disable || instr_ready) begin
            r_pc          <= w_fetch_pc;
            r_instr_valid <= 1'b0;
            if (run) begin
              r_state     <= ST_REQ;
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_fetch_pc;
            end else begin
              r_state  <= ST_IDLE;
              r_halted <= 1'b1;
            end
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
          r_pend_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        global_disable;
  logic [31:0] delta_instruction;
  logic [31:0] pc;
  logic        halted;
  logic [15:0] stall_count;

  int n_checks;
  int n_fails;

  fetch_controller #(
    .RESET_PC (32'h0000_0000),
    .STALL_W  (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .run               (run),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_data         (imem_data),
    .instr_valid       (instr_valid),
    .instr             (instr),
    .instr_ready       (instr_ready),
    .global_disable    (global_disable),
    .delta_instruction (delta_instruction),
    .pc                (pc),
    .halted            (halted),
    .stall_count       (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_halted"}, {31'd0, halted}, 32'd1);
    check_eq({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check_eq({tag, "_addr"}, imem_addr, 32'h0000_0000);
    check_eq({tag, "_pc"}, pc, 32'h0000_0000);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check_eq({tag, "_instr"}, instr, 32'h0000_0000);
    check_eq({tag, "_stall"}, {16'd0, stall_count}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    global_disable = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    imem_data = 32'h0000_0000;
    delta_instruction = 32'h0000_0000;
    do_reset();
    check_reset_state("rst");

    // Back-to-back fetches with same-cycle ack
    run = 1'b1;
    imem_ack = 1'b1;
    imem_data = 32'hE3A0_1001;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("seq_req%0d", i), {31'd0, imem_req}, 32'd1);
      check_eq($sformatf("seq_addr%0d", i), imem_addr, 32'(i * 4));
      tick();
      check_eq($sformatf("seq_valid%0d", i), {31'd0, instr_valid}, 32'd1);
      check_eq($sformatf("seq_instr%0d", i), instr, 32'hE3A0_1001);
    end
    run = 1'b0;
    tick();
    check_eq("halt_after_accept", {31'd0, halted}, 32'd1);
    check_eq("halt_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("halt_pc", pc, 32'h0000_000C);

    // Delayed ack: address held four cycles, three stall cycles counted
    do_reset();
    run = 1'b1;
    instr_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("stall_addr%0d", k), imem_addr, 32'h0000_0000);
      check_eq($sformatf("stall_req%0d", k), {31'd0, imem_req}, 32'd1);
      tick();
    end
    check_eq("stall_addr3", imem_addr, 32'h0000_0000);
    check_eq("stall_cnt", {16'd0, stall_count}, 32'd3);
    imem_ack = 1'b1;
    imem_data = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("stall_instr", instr, 32'h1234_5678);

    // Decode back-pressure holds the buffered instruction
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("hold_valid%0d", k), {31'd0, instr_valid}, 32'd1);
      check_eq($sformatf("hold_instr%0d", k), instr, 32'h1234_5678);
      check_eq($sformatf("hold_req%0d", k), {31'd0, imem_req}, 32'd0);
    end
    check_eq("hold_pc", pc, 32'h0000_0004);

    // Redirect from HOLD (pc 4, +2) lands on 0xC
    global_disable = 1'b1;
    delta_instruction = 32'd2;
    tick();
    global_disable = 1'b0;
    check_eq("rd1_addr", imem_addr, 32'h0000_000C);
    check_eq("rd1_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    imem_data = 32'hCAFE_0001;
    tick();
    imem_ack = 1'b0;
    check_eq("rd1_hold_pc", pc, 32'h0000_0010);

    // pc 0x10 in HOLD, delta -2 -> 0x08
    global_disable = 1'b1;
    delta_instruction = 32'hFFFF_FFFE;
    tick();
    global_disable = 1'b0;
    check_eq("neg_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("neg_addr", imem_addr, 32'h0000_0008);
    check_eq("neg_pc", pc, 32'h0000_0008);

    // Redirect coincident with ack: 8 + 6*4 = 0x20, data dropped
    global_disable = 1'b1;
    delta_instruction = 32'd6;
    imem_ack = 1'b1;
    imem_data = 32'hBAD0_0001;
    tick();
    imem_ack = 1'b0;
    global_disable = 1'b0;
    check_eq("coin_addr", imem_addr, 32'h0000_0020);
    check_eq("coin_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("coin_req", {31'd0, imem_req}, 32'd1);

    // Redirect during REQ at 0x20, ack two cycles later -> 0x30
    global_disable = 1'b1;
    delta_instruction = 32'd4;
    tick();
    global_disable = 1'b0;
    check_eq("pend_addr0", imem_addr, 32'h0000_0020);
    tick();
    check_eq("pend_addr1", imem_addr, 32'h0000_0020);
    imem_ack = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check_eq("pend_addr", imem_addr, 32'h0000_0030);
    check_eq("pend_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("pend_pc", pc, 32'h0000_0030);

    // Two chained redirects while pending: 0x30 + 4 + 4 = 0x38
    global_disable = 1'b1;
    delta_instruction = 32'd1;
    tick();
    tick();
    global_disable = 1'b0;
    imem_ack = 1'b1;
    imem_data = 32'hBAD0_0002;
    tick();
    check_eq("chain_addr", imem_addr, 32'h0000_0038);
    check_eq("chain_valid", {31'd0, instr_valid}, 32'd0);

    // run dropped mid-request: completes, holds, then idles
    run = 1'b0;
    imem_data = 32'hA5A5_0001;
    tick();
    imem_ack = 1'b0;
    check_eq("stop_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("stop_instr", instr, 32'hA5A5_0001);
    check_eq("stop_halted", {31'd0, halted}, 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check_eq("stop_idle", {31'd0, halted}, 32'd1);
    check_eq("stop_req", {31'd0, imem_req}, 32'd0);
    check_eq("stop_pc", pc, 32'h0000_003C);

    // Reset mid-request, then a late ack must be ignored
    run = 1'b1;
    tick();
    check_eq("mid_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run = 1'b0;
    imem_ack = 1'b1;
    imem_data = 32'h0BAD_0BAD;
    check_reset_state("mid_rst");
    tick();
    imem_ack = 1'b0;
    check_reset_state("late_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter STALL_W, default 16, width of stall counter.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  reset: synchronous and active-low.
REQ-005 run  input  1  fetch enable; 0 requests a halt.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  32  read address, word aligned.
REQ-008 imem_ack  input  1  memory returns imem_data this cycle.
REQ-009 imem_data  input  32  instruction word.
REQ-010 instr_valid  output  1  instr holds an instruction for decode.
REQ-011 instr  output  32  buffered instruction.
REQ-012 instr_ready  input  1  decode accepts instr this cycle.
REQ-013 global_disable  input  1  redirect from Execute (branch taken).
REQ-014 delta_instruction  input  32  signed redirect offset in instructions, valid with global_disable.
REQ-015 pc  output  32  address of next instruction to fetch.
REQ-016 halted  output  1  high while in IDLE.
REQ-017 stall_count  output  STALL_W  cycles spent waiting for imem_ack since last reset.

Function
REQ-018 FSM states SHALL be IDLE, REQ, HOLD; all outputs registered.
REQ-019 IDLE: run=1 -> REQ next cycle; imem_req rises one cycle after run is seen high.
REQ-020 REQ: imem_req=1, imem_addr=pc, both stable until imem_ack.
REQ-021 REQ with imem_ack, no redirect pending: instr<=imem_data, pc<=pc+4, -> HOLD; instr_valid=1 the cycle after ack.
REQ-022 HOLD: instr_valid=1, instr stable until instr_ready; on instr_ready -> REQ if run=1 else IDLE.
REQ-023 Redirect target SHALL be pc + (delta_instruction << 2), 32-bit wrap-around, no overflow flag.
REQ-024 global_disable in IDLE or HOLD: pc<=target next cycle; HOLD drops instr_valid next cycle and -> REQ (or IDLE if run=0).
REQ-025 global_disable in REQ: address not changed; target latched as pending redirect; on imem_ack data discarded, pc<=pending target, -> REQ.
REQ-026 Second global_disable while redirect pending: SHALL recompute from the pending target (chained offset).
REQ-027 global_disable coincident with imem_ack: data discarded, pc<=target, -> REQ.
REQ-028 global_disable coincident with instr_ready in HOLD: redirect wins; pc<=target, no pc+4.
REQ-029 run=0 in REQ: outstanding request completes normally; then HOLD, then IDLE after acceptance.
REQ-030 stall_count increments each REQ cycle with imem_ack=0; saturates at all-ones.
REQ-031 halted=1 exactly when state is IDLE.

Reset
REQ-032 rst_n=0 at a clk edge: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, halted=1, stall_count=0, pending redirect cleared.
REQ-033 Reset mid-request SHALL abandon the request; a late imem_ack after reset SHALL be ignored.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enumeration and constant PC_STEP=4.
REQ-035 Sub-module pc_next (combinational: pc, delta, redirect -> next pc) SHALL be the only sub-module.

Verification
REQ-036 Reset, run=1, imem_ack same cycle as req with data 32'hE3A01001, instr_ready=1 -> addresses 0,4,8 fetched, instr_valid pulses carry memory data.
REQ-037 imem_ack delayed 3 cycles -> imem_addr stable 4 cycles, stall_count=3.
REQ-038 HOLD with instr_ready=0 for 5 cycles -> instr and instr_valid unchanged, no new imem_req.
REQ-039 pc=32'h10 in HOLD, global_disable=1, delta=-2 -> instr_valid low next cycle, next imem_addr=32'h08.
REQ-040 global_disable delta=+4 during REQ at pc=32'h20, ack 2 cycles later -> data discarded, next imem_addr=32'h30.
REQ-041 rst_n=0 while imem_req=1, then ack arrives -> outputs at reset values, no instr_valid.
